// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO drain arbiter.
package fifo_arb_pkg;

  // Output buffer occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  // Width of a source index for n requesters (never less than one bit).
  function automatic int src_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector. The search starts at last_grant+1 and
// wraps modulo N. With FIFO_ARB_FULLEST_FIRST_EN defined, the request with
// the largest weight wins; ties go to the earliest position in that search.
module rr_select #(
  parameter int N  = 4,
  parameter int SW = 2,
  parameter int CW = 7
) (
  input  logic [N-1:0]    req,
  input  logic [SW-1:0]   last_grant,
  input  logic [N*CW-1:0] weights,
  output logic            grant_valid,
  output logic [SW-1:0]   grant_idx
);

  // Position of the k-th candidate after last_grant, wrapped into 0..N-1.
  function automatic int rr_pos(input logic [SW-1:0] base, input int k);
    int p;
    p = int'(base) + k;
    if (p >= N) p = p - N;
    return p;
  endfunction

`ifdef FIFO_ARB_FULLEST_FIRST_EN
  logic [CW-1:0] w [N];
  logic [CW-1:0] best;

  for (genvar i = 0; i < N; i++) begin : g_w
    assign w[i] = weights[i*CW +: CW];
  end

  // Walk in round-robin order; only a strictly larger weight displaces the
  // current pick, so ties stay with the earlier round-robin position.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    best        = '0;
    for (int k = 1; k <= N; k++) begin
      if (req[rr_pos(last_grant, k)] &&
          (!grant_valid || w[rr_pos(last_grant, k)] > best)) begin
        grant_valid = 1'b1;
        grant_idx   = SW'(rr_pos(last_grant, k));
        best        = w[rr_pos(last_grant, k)];
      end
    end
  end
`else
  // Occupancy is ignored in the pure round-robin build.
  logic unused_weights;
  assign unused_weights = ^weights;

  // First requester found in round-robin order wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (req[rr_pos(last_grant, k)] && !grant_valid) begin
        grant_valid = 1'b1;
        grant_idx   = SW'(rr_pos(last_grant, k));
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains N first-word-fall-through FIFOs onto a single valid/ready stream,
// tagging each word with its source index. A 2-entry buffer (head + skid)
// means pop permission depends only on registered occupancy, so there is
// no combinational path from out_ready to fifo_rd_en.
// Optional build: FIFO_ARB_FULLEST_FIRST_EN grants the fullest FIFO first.
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_FIFOS     = 4,
  parameter  int DWIDTH      = 16,
  parameter  int COUNT_WIDTH = 7,
  localparam int SRC_WIDTH   = src_width(N_FIFOS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_FIFOS*DWIDTH-1:0]      fifo_dout,
  input  logic [N_FIFOS-1:0]             fifo_empty,
  input  logic [N_FIFOS*COUNT_WIDTH-1:0] fifo_data_count,
  output logic [N_FIFOS-1:0]             fifo_rd_en,
  output logic [DWIDTH-1:0]              out_data,
  output logic [SRC_WIDTH-1:0]           out_src,
  output logic                           out_valid,
  input  logic                           out_ready
);

  typedef struct packed {
    logic [SRC_WIDTH-1:0] src;
    logic [DWIDTH-1:0]    data;
  } entry_t;

  buf_state_t           state_q, state_d;
  entry_t               head_q, head_d;
  entry_t               skid_q, skid_d;
  logic [SRC_WIDTH-1:0] last_grant_q, last_grant_d;

  logic                 grant_valid;
  logic [SRC_WIDTH-1:0] grant_idx;
  logic                 can_pop, pop, deq;
  entry_t               cap;
  logic [DWIDTH-1:0]    dout_arr [N_FIFOS];

  for (genvar i = 0; i < N_FIFOS; i++) begin : g_dout
    assign dout_arr[i] = fifo_dout[i*DWIDTH +: DWIDTH];
  end

  rr_select #(
    .N  (N_FIFOS),
    .SW (SRC_WIDTH),
    .CW (COUNT_WIDTH)
  ) u_sel (
    .req         (~fifo_empty),
    .last_grant  (last_grant_q),
    .weights     (fifo_data_count),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign out_valid = (state_q != EMPTY);
  assign out_data  = head_q.data;
  assign out_src   = head_q.src;

  // Pop/grant decode and buffer next-state. Popping is suppressed during
  // reset so upstream words are not lost while the buffer is cleared.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    skid_d       = skid_q;
    last_grant_d = last_grant_q;
    can_pop      = (state_q != TWO);
    pop          = can_pop & grant_valid & ~rst;
    deq          = out_valid & out_ready;
    cap.src      = grant_idx;
    cap.data     = dout_arr[grant_idx];
    fifo_rd_en   = pop ? (N_FIFOS'(1) << grant_idx) : '0;
    if (pop) last_grant_d = grant_idx;

    unique case (state_q)
      EMPTY: begin
        if (pop) begin
          state_d = ONE;
          head_d  = cap;
        end
      end
      ONE: begin
        if (pop && deq) begin
          head_d = cap;
        end else if (pop) begin
          state_d = TWO;
          skid_d  = cap;
        end else if (deq) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (deq) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Buffer and round-robin pointer registers; reset makes FIFO 0 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      head_q       <= '0;
      skid_q       <= '0;
      last_grant_q <= SRC_WIDTH'(N_FIFOS - 1);
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      skid_q       <= skid_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: behavioural upstream FIFOs, a reference
// arbitration model and an output scoreboard.
module tb_fifo_drain_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 7;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] fifo_dout;
  logic [N-1:0]    fifo_empty;
  logic [N*CW-1:0] fifo_data_count;
  logic [N-1:0]    fifo_rd_en;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_valid;
  logic            out_ready;

  always #5 clk = ~clk;

  fifo_drain_arbiter #(.N_FIFOS(N), .DWIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_dout       (fifo_dout),
    .fifo_empty      (fifo_empty),
    .fifo_data_count (fifo_data_count),
    .fifo_rd_en      (fifo_rd_en),
    .out_data        (out_data),
    .out_src         (out_src),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  logic [DW-1:0] fq [N][$];
  entry_t        sb [$];
  int            occ, lg, cyc;
  int            deq_cnt, first_deq, last_deq;
  int            n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i]                = (fq[i].size() == 0);
      fifo_dout[i*DW +: DW]        = (fq[i].size() != 0) ? fq[i][0] : '0;
      fifo_data_count[i*CW +: CW]  = CW'(fq[i].size());
    end
  endtask

  // One clock: check at negedge against the model, update model after edge.
  task automatic tick();
    bit   any, pop, deq;
    int   sel, best, p;
    logic [N-1:0] er;
    @(negedge clk);
    cyc++;
    any = 0; sel = 0; best = 0;
    for (int k = 1; k <= N; k++) begin
      p = (lg + k) % N;
      if (fq[p].size() != 0) begin
`ifdef FIFO_ARB_FULLEST_FIRST_EN
        if (!any || fq[p].size() > best) begin
          any = 1; sel = p; best = fq[p].size();
        end
`else
        if (!any) begin
          any = 1; sel = p;
        end
`endif
      end
    end
    pop = !rst && occ < 2 && any;
    er  = pop ? N'(1 << sel) : '0;
    chk("rd_en", 32'(fifo_rd_en), 32'(er));
    deq = 0;
    if (!rst) begin
      chk("valid", 32'(out_valid), 32'(occ != 0));
      if (occ != 0) begin
        chk("data", 32'(out_data), 32'(sb[0].data));
        chk("src", 32'(out_src), 32'(sb[0].src));
        deq = out_ready;
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      occ = 0; lg = N - 1; sb.delete();
    end else begin
      if (deq) begin
        void'(sb.pop_front());
        if (deq_cnt == 0) first_deq = cyc;
        last_deq = cyc;
        deq_cnt++;
      end
      if (pop) begin
        sb.push_back('{src: 2'(sel), data: fq[sel][0]});
        void'(fq[sel].pop_front());
        lg = sel;
      end
      occ = occ + int'(pop) - int'(deq);
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    cyc = 0; occ = 0; lg = N - 1; deq_cnt = 0; first_deq = 0; last_deq = 0;
    rst = 1'b1;
    out_ready = 1'b0;
    drive();

    // Reset state
    do_reset();
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_src", 32'(out_src), 0);

    // Single source: FIFO 2 holds A1, A2
    out_ready = 1'b1;
    fq[2].push_back(16'h00A1);
    fq[2].push_back(16'h00A2);
    drive();
    #1 chk("t1_rd_en", 32'(fifo_rd_en), 32'h4);
    run(5);
    chk("t1_idle", 32'(out_valid), 0);

    // Round-robin: 3 words in every FIFO
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) fq[i].push_back(DW'(16'h1000 * (i + 1) + k));
    drive();
    deq_cnt = 0;
    run(16);
    chk("rr_words", 32'(deq_cnt), 12);
    chk("rr_span", 32'(last_deq - first_deq + 1), 12);

    // Back-pressure: two sources, consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fq[0].push_back(DW'(16'hB000 + k));
      fq[3].push_back(DW'(16'hB300 + k));
    end
    drive();
    run(5);
    chk("bp_stall_rd_en", 32'(fifo_rd_en), 0);
    chk("bp_stall_data", 32'(out_data), 32'hB000);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || fq[0].size() != 0 || fq[3].size() != 0); i++) tick();
    chk("bp_drained", 32'(sb.size() + fq[0].size() + fq[3].size()), 0);

    // Sparse / pointer wrap
    do_reset();
    out_ready = 1'b1;
    fq[1].push_back(16'hC100);
    drive();
    #1 chk("wrap_first", 32'(fifo_rd_en), 32'h2);
    tick();
    fq[0].push_back(16'hC000);
    fq[1].push_back(16'hC101);
    drive();
    #1 chk("wrap_second", 32'(fifo_rd_en), 32'h1);
    run(5);

    // Mid-operation reset while the buffer is full
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fq[0].push_back(DW'(16'hD000 + k));
      fq[2].push_back(DW'(16'hD200 + k));
    end
    drive();
    run(3);
    chk("mr_full_rd_en", 32'(fifo_rd_en), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_regrant", 32'(fifo_rd_en), 32'h1);
    chk("mr_upstream", 32'(fq[0].size() + fq[2].size()), 4);
    out_ready = 1'b1;
    run(8);
    chk("mr_drained", 32'(sb.size()), 0);

    // Occupancy-weighted pick: counts {5,9,9,2}
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) fq[0].push_back(DW'(16'hE000 + k));
    for (int k = 0; k < 9; k++) fq[1].push_back(DW'(16'hE100 + k));
    for (int k = 0; k < 9; k++) fq[2].push_back(DW'(16'hE200 + k));
    for (int k = 0; k < 2; k++) fq[3].push_back(DW'(16'hE300 + k));
    drive();
`ifdef FIFO_ARB_FULLEST_FIRST_EN
    #1 chk("ff_grant", 32'(fifo_rd_en), 32'h2);
`else
    #1 chk("ff_grant", 32'(fifo_rd_en), 32'h1);
`endif
    out_ready = 1'b1;
    run(30);
    chk("ff_drained", 32'(sb.size() + occ), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/fifo_drain_arbiter.md
Name: fifo_drain_arbiter

Overview:
- Drains N upstream `fifo` instances, which are first-word-fall-through: `dout` is valid whenever `empty`=0, and `rd_en` pops.
- Serialises their words onto one valid/ready stream, tagging each word with its source index.
- Sits directly downstream of the per-channel FIFOs and feeds the single consumer (engine dispatch).
- Holds a 2-entry output buffer, so no combinational path runs from `out_ready` to `fifo_rd_en`.

Parameters:
- N_FIFOS, 4, number of upstream FIFOs (2..16).
- DWIDTH, 16, data width; must match the upstream `fifo` DWIDTH.
- COUNT_WIDTH, 7, width of the upstream `data_count`.
- SRC_WIDTH, $clog2(N_FIFOS), source index width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_dout  in  N_FIFOS*DWIDTH  packed head words; FIFO i occupies bits [i*DWIDTH +: DWIDTH].
- fifo_empty  in  N_FIFOS  per-FIFO empty flag.
- fifo_data_count  in  N_FIFOS*COUNT_WIDTH  per-FIFO occupancy; used only with the optional feature.
- fifo_rd_en  out  N_FIFOS  one-hot pop strobe; at most one bit high per cycle.
- out_data  out  DWIDTH  word at the buffer head.
- out_src  out  SRC_WIDTH  index of the FIFO that `out_data` came from.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  consumer accepts `out_data` when `out_valid`=1 and `out_ready`=1.

Behaviour:
- Reset:
  - `fifo_rd_en`=0, `out_valid`=0, `out_data`=0, `out_src`=0.
  - Buffer state = EMPTY.
  - Round-robin pointer `last_grant` = N_FIFOS-1, so FIFO 0 has first priority.
  - A reset mid-operation discards buffered words; upstream FIFOs are untouched.
- Buffer FSM over occupancy: EMPTY(0), ONE(1), TWO(2).
  - `head` register drives the outputs; `skid` register holds the second entry.
- Pop permission (`can_pop`):
  - `can_pop` = state is EMPTY or ONE.
  - It depends only on registered state, never on `out_ready`.
- Grant:
  - If `can_pop` and any `fifo_empty[i]`=0, select the first non-empty index searching `last_grant`+1, +2, … modulo N_FIFOS.
  - Assert `fifo_rd_en[sel]`=1 and capture `fifo_dout[sel]` with `sel` in the same cycle.
  - Update `last_grant`<=`sel`.
  - No grant means `fifo_rd_en`=0 and `last_grant` holds.
- `deq` = `out_valid` & `out_ready`. Transitions (pop, deq):
  - EMPTY: pop → ONE, `head`<=captured word. No pop → EMPTY.
  - ONE, pop & deq: stays ONE, `head`<=captured word.
  - ONE, pop & !deq: → TWO, `skid`<=captured word.
  - ONE, !pop & deq: → EMPTY.
  - ONE, !pop & !deq: holds.
  - TWO, deq (pop impossible): → ONE, `head`<=`skid`.
  - TWO, !deq: holds.
- `out_valid` = state≠EMPTY.
- `out_data` and `out_src` are stable while `out_valid`=1 and `out_ready`=0.
- Latency: a word popped in cycle t appears on `out_data` in cycle t+1.
- Throughput: one word per cycle sustained while `out_ready`=1 and at least one FIFO is non-empty.
- Ordering:
  - Per-source order is preserved.
  - Cross-source order follows grant order.
- Fairness: with k continuously non-empty FIFOs, each is granted exactly once per k grants.
- Pointer wrap: `last_grant`=N_FIFOS-1 searches from 0.
- Empty FIFOs are never popped; `fifo_rd_en[i]` is 0 whenever `fifo_empty[i]`=1.

Optional Feature:
- Macro: FIFO_ARB_FULLEST_FIRST_EN.
- Defined:
  - Grant goes to the non-empty FIFO with the largest `fifo_data_count`.
  - Ties are broken by round-robin order from `last_grant`+1.
  - The choice is combinational in the same cycle; `last_grant` is still updated.
- Undefined:
  - Pure round-robin.
  - `fifo_data_count` is ignored; synthesis may prune it.
  - The port list is identical in both builds.

Decomposition:
- Package `fifo_arb_pkg`:
  - buffer state enum `buf_state_t` {EMPTY, ONE, TWO}.
  - localparam function `src_width(n)`.
- Sub-module `rr_select`:
  - combinational; inputs: request vector, `last_grant`, optional per-request weights.
  - outputs: `grant_valid`, `grant_idx`.
  - Rotate-and-priority-encode; hosts the fullest-first compare under the macro.

Test Plan:
- Reset then single source: only FIFO 2 holds 0xA1,0xA2, `out_ready`=1 → `fifo_rd_en`=4'b0100 for 2 cycles; `out_data` 0xA1 then 0xA2 with `out_src`=2 on consecutive cycles; then `out_valid`=0.
- Round-robin: all 4 FIFOs hold 3 words each, `out_ready`=1 → `out_src` sequence 0,1,2,3,0,1,2,3,0,1,2,3; 12 words in 12 cycles after first pop.
- Back-pressure: `out_ready`=0 with 2 FIFOs non-empty → exactly 2 pops (state TWO) then `fifo_rd_en`=0; `out_data` held. Raise `out_ready` → both words drained in order, then popping resumes.
- Sparse/wrap: `last_grant`=3, only FIFO 1 non-empty → FIFO 1 granted; next grant with FIFOs 0,1 non-empty → FIFO 0 is not skipped, order 0 after 1.
- Mid-operation reset: `rst` high for 1 cycle while in TWO → next cycle `out_valid`=0, `fifo_rd_en`=0; next grant starts at FIFO 0.
- FULLEST_FIRST_EN build: data_count {5,9,9,2} → grant FIFO 1 (tie with 2, RR order from `last_grant`=3). Undefined build → grant FIFO 0.
